// File: rtl/seg_display_bank_pkg.sv
// Shared constants for the seven-segment display bank: blank pattern, source modes, glyph table.
package seg_display_bank_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic       MODE_WORD = 1'b0;
    localparam logic       MODE_BYTE = 1'b1;

    // Active-low gfedcba glyphs; b and d are lower-case
    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;
    localparam logic [6:0] GLYPH_4 = 7'h19;
    localparam logic [6:0] GLYPH_5 = 7'h12;
    localparam logic [6:0] GLYPH_6 = 7'h02;
    localparam logic [6:0] GLYPH_7 = 7'h78;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h10;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h03;
    localparam logic [6:0] GLYPH_C = 7'h46;
    localparam logic [6:0] GLYPH_D = 7'h21;
    localparam logic [6:0] GLYPH_E = 7'h06;
    localparam logic [6:0] GLYPH_F = 7'h0E;

endpackage

// File: rtl/seg_display_bank_hex7seg_decode.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module hex7seg_decode
    import seg_display_bank_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg_c
);

    always_comb begin
        o_seg_c = SEG_BLANK;
        case (i_hex)
            4'h0: o_seg_c = GLYPH_0;
            4'h1: o_seg_c = GLYPH_1;
            4'h2: o_seg_c = GLYPH_2;
            4'h3: o_seg_c = GLYPH_3;
            4'h4: o_seg_c = GLYPH_4;
            4'h5: o_seg_c = GLYPH_5;
            4'h6: o_seg_c = GLYPH_6;
            4'h7: o_seg_c = GLYPH_7;
            4'h8: o_seg_c = GLYPH_8;
            4'h9: o_seg_c = GLYPH_9;
            4'hA: o_seg_c = GLYPH_A;
            4'hB: o_seg_c = GLYPH_B;
            4'hC: o_seg_c = GLYPH_C;
            4'hD: o_seg_c = GLYPH_D;
            4'hE: o_seg_c = GLYPH_E;
            4'hF: o_seg_c = GLYPH_F;
            default: o_seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_display_bank.sv
// N-digit hex display bank: direct word or PS2 byte-history source, leading-zero blanking,
// optional per-digit blinking enabled by defining SEG_BLINK_EN.
module seg_display_bank
    import seg_display_bank_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned BLINK_DIV  = 25000000
)(
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [4*NUM_DIGITS-1:0]   wr_data,
    input  logic                      byte_valid,
    input  logic [7:0]                byte_data,
    input  logic                      mode,
    input  logic                      lz_blank_en,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    output logic [7*NUM_DIGITS-1:0]   seg_out,
    output logic [7:0]                byte_count,
    output logic                      byte_dropped
);

    localparam int unsigned W  = 4 * NUM_DIGITS;
    localparam int unsigned SW = 7 * NUM_DIGITS;

    logic [W-1:0]                  r_contents;
    logic [W-1:0]                  w_shifted;
    logic                          w_byte_mode;
    logic [NUM_DIGITS-1:0][6:0]    w_glyph;
    logic [NUM_DIGITS-1:0]         w_lz_blank;
    logic [NUM_DIGITS-1:0]         w_blink_blank;
    logic [SW-1:0]                 w_seg_next;

    assign w_byte_mode = (mode == MODE_BYTE);

    // Byte history enters from the right; a single digit keeps only the low nibble
    generate
        if (NUM_DIGITS == 1) begin : g_shift_one
            assign w_shifted = byte_data[3:0];
        end else begin : g_shift_many
            assign w_shifted = {r_contents[W-9:0], byte_data};
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_contents   <= '0;
            byte_count   <= 8'd0;
            byte_dropped <= 1'b0;
        end else begin
            byte_dropped <= 1'b0;
            if (wr_en) begin
                r_contents <= wr_data;
                if (w_byte_mode && byte_valid) begin
                    byte_dropped <= 1'b1;
                end
            end else if (w_byte_mode && byte_valid) begin
                r_contents <= w_shifted;
                byte_count <= byte_count + 8'd1;
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
            hex7seg_decode u_dec (
                .i_hex   (r_contents[4*g +: 4]),
                .o_seg_c (w_glyph[g])
            );
        end
    endgenerate

    // Leading-zero prefix chain walks from the most significant digit down
    always_comb begin
        logic v_all_zero;
        v_all_zero = 1'b1;
        w_lz_blank = '0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            v_all_zero    = v_all_zero && (r_contents[4*i +: 4] == 4'h0);
            w_lz_blank[i] = lz_blank_en && v_all_zero && (i != 0);
        end
    end

`ifdef SEG_BLINK_EN
    localparam int unsigned CNT_W = $clog2(BLINK_DIV);

    logic [CNT_W-1:0] r_blink_cnt;
    logic             r_blink_phase;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (r_blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt   <= r_blink_cnt + CNT_W'(1);
        end
    end

    assign w_blink_blank = r_blink_phase ? blink_mask : '0;
`else
    logic w_unused_blink;
    assign w_unused_blink = (^blink_mask) ^ (BLINK_DIV < 2);
    assign w_blink_blank  = '0;
`endif

    always_comb begin
        w_seg_next = '1;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            w_seg_next[7*i +: 7] = (w_lz_blank[i] || w_blink_blank[i]) ? SEG_BLANK : w_glyph[i];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seg_out <= '1;
        end else begin
            seg_out <= w_seg_next;
        end
    end

endmodule

// File: tb/tb_seg_display_bank.sv
// Directed bench for seg_display_bank (8 digits, BLINK_DIV=4); honours SEG_BLINK_EN.
module tb_seg_display_bank;

    localparam int unsigned N = 8;

    logic           clock = 1'b0;
    logic           reset;
    logic           wr_en;
    logic [4*N-1:0] wr_data;
    logic           byte_valid;
    logic [7:0]     byte_data;
    logic           mode;
    logic           lz_blank_en;
    logic [N-1:0]   blink_mask;
    logic [7*N-1:0] seg_out;
    logic [7:0]     byte_count;
    logic           byte_dropped;

    int n_vec = 0;
    int n_err = 0;

    seg_display_bank #(.NUM_DIGITS(N), .BLINK_DIV(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .mode         (mode),
        .lz_blank_en  (lz_blank_en),
        .blink_mask   (blink_mask),
        .seg_out      (seg_out),
        .byte_count   (byte_count),
        .byte_dropped (byte_dropped)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] glyph(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [7*N-1:0] exp_seg(input logic [4*N-1:0] c, input logic lz);
        logic [7*N-1:0] r;
        logic           run;
        r   = '1;
        run = 1'b1;
        for (int d = N - 1; d >= 0; d--) begin
            run = run && (c[4*d +: 4] == 4'h0);
            if (lz && run && d != 0) r[7*d +: 7] = 7'h7F;
            else                     r[7*d +: 7] = glyph(c[4*d +: 4]);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        tick();
        byte_valid = 1'b0;
    endtask

    logic [7*N-1:0] exp_rest;
    logic           blink_on;

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_data = '0; byte_valid = 1'b0; byte_data = 8'h00;
        mode = 1'b0; lz_blank_en = 1'b0; blink_mask = '0;
        tick(2);
        check("rst_seg",  64'(seg_out), 64'({7*N{1'b1}}));
        check("rst_cnt",  64'(byte_count), 64'(8'd0));
        check("rst_drop", 64'(byte_dropped), 64'(1'b0));

        // Reset mid-operation
        reset = 1'b0; wr_en = 1'b1; wr_data = 32'h12345678;
        tick();
        wr_en = 1'b0;
        tick();
        check("pre_reset_load", 64'(seg_out), 64'(exp_seg(32'h12345678, 1'b0)));
        #3 reset = 1'b1;
        #1;
        check("async_rst_seg", 64'(seg_out), 64'({7*N{1'b1}}));
        check("async_rst_cnt", 64'(byte_count), 64'(8'd0));
        #1 reset = 1'b0;
        tick(2);
        check("rst_clears_contents", 64'(seg_out), 64'(exp_seg(32'h0, 1'b0)));

        // Direct word load, two-edge latency
        wr_en = 1'b1; wr_data = 32'hDEADBEEF;
        tick();
        wr_en = 1'b0;
        check("latency_k", 64'(seg_out), 64'(exp_seg(32'h0, 1'b0)));
        tick();
        check("word_d7", 64'(seg_out[55:49]), 64'(7'b0100001));
        check("word_d0", 64'(seg_out[6:0]),   64'(7'b0001110));
        check("word_all", 64'(seg_out), 64'(exp_seg(32'hDEADBEEF, 1'b0)));

        // Bytes ignored in word mode
        byte_valid = 1'b1; byte_data = 8'h55;
        tick();
        byte_valid = 1'b0;
        check("m0_no_drop", 64'(byte_dropped), 64'(1'b0));
        tick();
        check("m0_byte_ignored", 64'(seg_out), 64'(exp_seg(32'hDEADBEEF, 1'b0)));
        check("m0_cnt", 64'(byte_count), 64'(8'd0));

        // Byte history
        mode = 1'b1; wr_en = 1'b1; wr_data = 32'h0;
        tick();
        wr_en = 1'b0;
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h1C);
        tick();
        check("hist_seg", 64'(seg_out), 64'(exp_seg(32'h001CF01C, 1'b0)));
        check("hist_cnt", 64'(byte_count), 64'(8'd3));
        lz_blank_en = 1'b1;
        tick();
        check("lz_d7", 64'(seg_out[55:49]), 64'(7'h7F));
        check("lz_d6", 64'(seg_out[48:42]), 64'(7'h7F));
        check("lz_d5", 64'(seg_out[41:35]), 64'(7'b1111001));
        check("lz_all", 64'(seg_out), 64'(exp_seg(32'h001CF01C, 1'b1)));

        // Mode change leaves contents and count alone
        mode = 1'b0;
        tick(2);
        check("mode_chg_seg", 64'(seg_out), 64'(exp_seg(32'h001CF01C, 1'b1)));
        check("mode_chg_cnt", 64'(byte_count), 64'(8'd3));
        mode = 1'b1;

        // Collision: write wins, byte dropped
        wr_en = 1'b1; wr_data = 32'hA5A5A5A5; byte_valid = 1'b1; byte_data = 8'h77;
        tick();
        wr_en = 1'b0; byte_valid = 1'b0;
        check("drop_pulse", 64'(byte_dropped), 64'(1'b1));
        check("drop_cnt", 64'(byte_count), 64'(8'd3));
        tick();
        check("drop_one_cycle", 64'(byte_dropped), 64'(1'b0));
        check("drop_seg", 64'(seg_out), 64'(exp_seg(32'hA5A5A5A5, 1'b1)));

        // All-zero contents with blanking
        wr_en = 1'b1; wr_data = 32'h0;
        tick();
        wr_en = 1'b0;
        tick();
        check("lz_zero", 64'(seg_out), 64'({{7{7'h7F}}, 7'b1000000}));

        // Byte counter wrap
        reset = 1'b1;
        #1 reset = 1'b0;
        for (int i = 0; i < 256; i++) begin
            send_byte(8'(i));
            if (i == 254) check("cnt_255", 64'(byte_count), 64'(8'd255));
        end
        check("cnt_wrap", 64'(byte_count), 64'(8'd0));
        tick();
        check("wrap_seg", 64'(seg_out), 64'(exp_seg(32'hFCFDFEFF, 1'b1)));

        // Blink: digit0 masked, counter from reset
        reset = 1'b1; blink_mask = 8'h01; lz_blank_en = 1'b0; mode = 1'b0;
        tick();
        #4;
        reset = 1'b0; wr_en = 1'b1; wr_data = 32'h87654321;
        exp_rest = exp_seg(32'h87654321, 1'b0);
        for (int n = 1; n <= 17; n++) begin
            @(posedge clock);
            #1;
            if (n == 1)  wr_en = 1'b0;
            if (n == 9)  wr_en = 1'b1;
            if (n == 10) wr_en = 1'b0;
            if (n >= 2) begin
`ifdef SEG_BLINK_EN
                blink_on = (((n - 1) / 4) % 2) == 1;
`else
                blink_on = 1'b0;
`endif
                check("blink_d0", 64'(seg_out[6:0]), 64'(blink_on ? 7'h7F : 7'b1111001));
                check("blink_rest", 64'(seg_out[55:7]), 64'(exp_rest[55:7]));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
